msg_sched: RTL and testbench
============================

// Module: msg_sched
// PURPOSE
//  SHA256 message schedule stage, directly downstream of the padding stage.
//  Captures one padded 512-bit block and streams W[0]..W[ROUNDS-1] as 32-bit words to the compression core.
//  W[0..15] come straight from the block; W[16..] are expanded on the fly in a 16-word sliding window.
//  Output uses a valid/ready handshake, so the compression core may stall the stream.
// PARAMETERS
//  ROUNDS   64  words emitted per block; legal range 17..64
// PORTS
//  clock       in   1    rising-edge clock
//  reset       in   1    asynchronous, active-high; clears all state
//  blk_valid   in   1    padded block available (driven by pad_msg_rdy; level, may stay high)
//  pad_mem     in   512  padded block; message byte i sits on bits [8i+7:8i]
//  blk_ack     out  1    1-cycle pulse on the edge that captures pad_mem
//  w_valid     out  1    w_data/w_idx valid
//  w_ready     in   1    consumer accepts word when w_valid&w_ready
//  w_data      out  32   schedule word W[w_idx]
//  w_idx       out  6    round index t, 0..ROUNDS-1
//  sched_done  out  1    1-cycle pulse after W[ROUNDS-1] is accepted
// BEHAVIOUR
//  Reset values: blk_ack=0, w_valid=0, w_data=0, w_idx=0, sched_done=0. Internal: state=IDLE, armed=1, window=0.
//  Word packing, big-endian: W[j] = {byte4j, byte4j+1, byte4j+2, byte4j+3}.
//   Example: W[0] = {pad_mem[7:0], pad_mem[15:8], pad_mem[23:16], pad_mem[31:24]}.
//  armed flag: cleared on capture; set on any cycle where blk_valid=0.
//   Prevents re-capturing the same held block.
//  FSM:
//   IDLE: when blk_valid & armed, load window w[0..15] = W[0..15], set t=0, pulse blk_ack, go to RUN.
//    Otherwise stay in IDLE.
//   RUN: w_valid=1, w_data=w[0], w_idx=t.
//    On handshake: w[i] <= w[i+1] for i=0..14, and t <= t+1.
//    w[15] <= s1(w[14]) + w[9] + s0(w[1]) + w[0], mod 2^32.
//    On handshake with t==ROUNDS-1: go to DONE.
//    Without a handshake: every output and all internal state hold.
//   DONE: sched_done=1 for exactly 1 cycle, w_valid=0, then go to IDLE.
//  s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
//  s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
//  Latency: capture on edge k; W[0] is presented with w_valid=1 in the cycle after edge k.
//   With w_ready held at 1, one word is accepted per cycle.
//   sched_done is high in cycle k+ROUNDS+1; the next capture can occur at the earliest at edge k+ROUNDS+2.
//  Registered outputs: w_valid, w_data, w_idx, blk_ack and sched_done are all registers; there are no combinational input-to-output paths.
//  blk_valid during RUN/DONE: ignored; no ack is issued. pad_mem changes after capture have no effect.
//  If blk_valid is still high on return to IDLE while armed=0: no capture until blk_valid drops, then rises again.
//  Asserting reset mid-block: outputs drop to their reset values immediately; the partial stream is abandoned.
//   No sched_done is issued for that block.
//  w_idx width is fixed at 6 bits; t never exceeds ROUNDS-1.
// TESTING
//  T1 Block "abc": W0=61626380, W15=00000018, rest zero; w_ready=1.
//   Required: W0=61626380, W16=61626380, W17=000F0000, W18=7DA86405, W19=600003C6, W63=12B1EDEB.
//   Required: sched_done pulses in cycle k+65.
//  T2 Backpressure: T1 block, w_ready toggled pseudo-randomly.
//   Required: identical 64-word sequence, w_data/w_idx stable while stalled, no word dropped or duplicated.
//  T3 Level hold: blk_valid held high for 200 cycles.
//   Required: exactly one blk_ack and one 64-word stream.
//   Then drop blk_valid for 1 cycle, raise it again -> second capture and stream.
//  T4 Reset mid-stream: assert reset at t=30 (async, off-edge).
//   Required: w_valid=0 immediately, no sched_done, and a fresh block afterwards yields the T1 sequence from W0.
//  T5 Block input change: change pad_mem and pulse blk_valid during RUN.
//   Required: stream still equals the originally captured block, no blk_ack during RUN.
//  T6 ROUNDS=17: exactly 17 words, last is W16=61626380, then sched_done.

Source files
------------

// File: rtl/msg_sched.sv
// SHA-256 message schedule stage.
// Captures one padded 512-bit block, then streams W[0]..W[ROUNDS-1] over a
// valid/ready port. W[16..] are expanded on the fly from a 16-word sliding
// window whose head (w[0]) is always the word currently on the output.
module msg_sched #(
    parameter int ROUNDS = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         blk_valid,
    input  logic [511:0] pad_mem,
    output logic         blk_ack,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_idx,
    output logic         sched_done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    state_t      state, state_nx;
    logic        armed;
    logic [31:0] win [16];
    logic [5:0]  t;
    logic [31:0] w_new;
    logic        cap, hs, last;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Head of the window and the round counter are the output registers.
    assign w_data = win[0];
    assign w_idx  = t;

    // Next-state decode: capture in IDLE, advance on handshake in RUN.
    always_comb begin
        state_nx = state;
        cap      = 1'b0;
        hs       = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (blk_valid && armed) begin
                    cap      = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                hs   = w_valid && w_ready;
                last = hs && (t == LAST_T);
                if (last) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Word that enters the tail of the window when the head is consumed.
    always_comb begin
        w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Re-arm only once blk_valid has been seen low, so a held block is taken once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)           armed <= 1'b1;
        else if (cap)        armed <= 1'b0;
        else if (!blk_valid) armed <= 1'b1;
    end

    // Handshake/status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blk_ack    <= 1'b0;
            sched_done <= 1'b0;
            w_valid    <= 1'b0;
        end else begin
            blk_ack    <= cap;
            sched_done <= last;
            if (cap)       w_valid <= 1'b1;
            else if (last) w_valid <= 1'b0;
        end
    end

    // Round counter; holds on the final word so it never passes ROUNDS-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)            t <= '0;
        else if (cap)         t <= '0;
        else if (hs && !last) t <= t + 6'd1;
    end

    // Sliding window: big-endian load on capture, shift plus expand on handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (cap) begin
            for (int j = 0; j < 16; j++)
                win[j] <= {pad_mem[32*j +: 8], pad_mem[32*j+8 +: 8],
                           pad_mem[32*j+16 +: 8], pad_mem[32*j+24 +: 8]};
        end else if (hs) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= w_new;
        end
    end

endmodule

// File: tb/tb_msg_sched.sv
// Bench for msg_sched: reference schedule computed from the SHA-256
// recurrence over a full 64-entry array, compared against the streamed words.
module tb_msg_sched;

    logic         clock = 1'b0;
    logic         reset;
    logic         blk_valid, w_ready;
    logic [511:0] pad_mem;
    logic         blk_ack, w_valid, sched_done;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;

    logic         blk_valid17, w_ready17;
    logic         blk_ack17, w_valid17, sched_done17;
    logic [31:0]  w_data17;
    logic [5:0]   w_idx17;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_w [64];
    logic [31:0] q_data [$];
    int          q_idx  [$];
    int          acks, dones, ack_cyc, done_cyc, stall_err;

    msg_sched #(.ROUNDS(64)) dut (
        .clock(clock), .reset(reset), .blk_valid(blk_valid), .pad_mem(pad_mem),
        .blk_ack(blk_ack), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_idx(w_idx), .sched_done(sched_done)
    );

    msg_sched #(.ROUNDS(17)) dut17 (
        .clock(clock), .reset(reset), .blk_valid(blk_valid17), .pad_mem(pad_mem),
        .blk_ack(blk_ack17), .w_valid(w_valid17), .w_ready(w_ready17), .w_data(w_data17),
        .w_idx(w_idx17), .sched_done(sched_done17)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Full schedule straight from the SHA-256 definition.
    task automatic compute_ref(input logic [511:0] b);
        for (int j = 0; j < 16; j++)
            ref_w[j] = {b[32*j +: 8], b[32*j+8 +: 8], b[32*j+16 +: 8], b[32*j+24 +: 8]};
        for (int j = 16; j < 64; j++)
            ref_w[j] = (rr(ref_w[j-2], 17) ^ rr(ref_w[j-2], 19) ^ (ref_w[j-2] >> 10))
                     + ref_w[j-7]
                     + (rr(ref_w[j-15], 7) ^ rr(ref_w[j-15], 18) ^ (ref_w[j-15] >> 3))
                     + ref_w[j-16];
    endtask

    function automatic logic [511:0] abc_block();
        logic [511:0] b;
        b = '0;
        b[7:0]     = 8'h61;
        b[15:8]    = 8'h62;
        b[23:16]   = 8'h63;
        b[31:24]   = 8'h80;
        b[511:504] = 8'h18;
        return b;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Runs the main DUT cycle by cycle (sampling on negedge) and records
    // accepted words, ack/done pulses and any change of a stalled word.
    task automatic collect(input int max_cyc, input bit rnd_ready, input bit stop_on_done,
                           input int stop_idx, input bit poke);
        logic [31:0] pd;
        logic [5:0]  pi;
        bit          pv, phs;
        q_data.delete(); q_idx.delete();
        acks = 0; dones = 0; ack_cyc = -1; done_cyc = -1; stall_err = 0;
        pv = 0; phs = 0; pd = '0; pi = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clock);
            if (poke) begin
                if (c == 10) begin pad_mem = rand_block(); blk_valid = 1'b0; end
                if (c == 11) blk_valid = 1'b1;
                if (c == 13) blk_valid = 1'b0;
            end
            if (stop_idx >= 0 && w_valid && int'(w_idx) == stop_idx) break;
            w_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (blk_ack) begin acks++; if (ack_cyc < 0) ack_cyc = c; end
            if (sched_done) begin dones++; done_cyc = c; end
            if (pv && !phs && w_valid && (w_data !== pd || w_idx !== pi)) stall_err++;
            phs = w_valid && w_ready;
            if (phs) begin q_data.push_back(w_data); q_idx.push_back(int'(w_idx)); end
            pv = w_valid; pd = w_data; pi = w_idx;
            if (stop_on_done && sched_done) break;
        end
    endtask

    task automatic idle_gap();
        blk_valid = 1'b0;
        w_ready   = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; blk_valid = 1'b0; w_ready = 1'b1; pad_mem = '0;
        blk_valid17 = 1'b0; w_ready17 = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++; if (blk_ack !== 1'b0) begin n_fail++; $display("FAIL reset_blk_ack: got %b exp 0", blk_ack); end
        n_checks++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_w_valid: got %b exp 0", w_valid); end
        n_checks++; if (w_data !== 32'h0) begin n_fail++; $display("FAIL reset_w_data: got %h exp 0", w_data); end
        n_checks++; if (w_idx !== 6'd0) begin n_fail++; $display("FAIL reset_w_idx: got %0d exp 0", w_idx); end
        n_checks++; if (sched_done !== 1'b0) begin n_fail++; $display("FAIL reset_sched_done: got %b exp 0", sched_done); end
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL idle_w_valid: got %b exp 0", w_valid); end
    endtask

    task automatic test_abc();
        logic [31:0] req [6];
        int          rix [6];
        req = '{32'h61626380, 32'h61626380, 32'h000F0000, 32'h7DA86405, 32'h600003C6, 32'h12B1EDEB};
        rix = '{0, 16, 17, 18, 19, 63};
        pad_mem = abc_block();
        compute_ref(pad_mem);
        blk_valid = 1'b1;
        collect(100, 1'b0, 1'b1, -1, 1'b0);
        n_checks++; if (q_data.size() != 64) begin n_fail++; $display("FAIL abc_count: got %0d exp 64", q_data.size()); end
        if (q_data.size() == 64) begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (q_data[rix[i]] !== req[i]) begin
                    n_fail++; $display("FAIL abc_W%0d: got %h exp %h", rix[i], q_data[rix[i]], req[i]);
                end
            end
            for (int i = 0; i < 64; i++) begin
                n_checks++;
                if (q_data[i] !== ref_w[i] || q_idx[i] != i) begin
                    n_fail++; $display("FAIL abc_word%0d: got %h/%0d exp %h/%0d", i, q_data[i], q_idx[i], ref_w[i], i);
                end
            end
        end
        n_checks++; if (ack_cyc != 1) begin n_fail++; $display("FAIL abc_ack_cycle: got %0d exp 1", ack_cyc); end
        n_checks++; if (done_cyc != 65) begin n_fail++; $display("FAIL abc_done_cycle: got %0d exp 65", done_cyc); end
        n_checks++; if (acks != 1) begin n_fail++; $display("FAIL abc_ack_count: got %0d exp 1", acks); end
        idle_gap();
        n_checks++; if (sched_done !== 1'b0) begin n_fail++; $display("FAIL abc_done_width: got %b exp 0", sched_done); end
    endtask

    task automatic test_backpressure();
        pad_mem = abc_block();
        compute_ref(pad_mem);
        blk_valid = 1'b1;
        collect(600, 1'b1, 1'b1, -1, 1'b0);
        n_checks++; if (q_data.size() != 64) begin n_fail++; $display("FAIL bp_count: got %0d exp 64", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 64; i++) begin
            n_checks++;
            if (q_data[i] !== ref_w[i] || q_idx[i] != i) begin
                n_fail++; $display("FAIL bp_word%0d: got %h/%0d exp %h/%0d", i, q_data[i], q_idx[i], ref_w[i], i);
            end
        end
        n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d changes exp 0", stall_err); end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d exp 1", dones); end
        idle_gap();
    endtask

    task automatic test_level_hold();
        pad_mem = abc_block();
        compute_ref(pad_mem);
        blk_valid = 1'b1;
        collect(200, 1'b0, 1'b0, -1, 1'b0);
        n_checks++; if (acks != 1) begin n_fail++; $display("FAIL hold_ack_count: got %0d exp 1", acks); end
        n_checks++; if (q_data.size() != 64) begin n_fail++; $display("FAIL hold_count: got %0d exp 64", q_data.size()); end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL hold_done_count: got %0d exp 1", dones); end
        blk_valid = 1'b0;
        @(negedge clock);
        blk_valid = 1'b1;
        collect(100, 1'b0, 1'b1, -1, 1'b0);
        n_checks++; if (acks != 1) begin n_fail++; $display("FAIL rearm_ack_count: got %0d exp 1", acks); end
        n_checks++; if (q_data.size() != 64) begin n_fail++; $display("FAIL rearm_count: got %0d exp 64", q_data.size()); end
        if (q_data.size() == 64) begin
            n_checks++; if (q_data[63] !== ref_w[63]) begin n_fail++; $display("FAIL rearm_W63: got %h exp %h", q_data[63], ref_w[63]); end
        end
        idle_gap();
    endtask

    task automatic test_reset_mid();
        int sd;
        pad_mem = abc_block();
        compute_ref(pad_mem);
        blk_valid = 1'b1;
        collect(100, 1'b0, 1'b0, 30, 1'b0);
        n_checks++; if (q_data.size() != 30) begin n_fail++; $display("FAIL rst_mid_pre_count: got %0d exp 30", q_data.size()); end
        blk_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_w_valid: got %b exp 0", w_valid); end
        n_checks++; if (w_idx !== 6'd0) begin n_fail++; $display("FAIL rst_mid_w_idx: got %0d exp 0", w_idx); end
        n_checks++; if (w_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_w_data: got %h exp 0", w_data); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        sd = 0;
        repeat (4) begin @(negedge clock); if (sched_done) sd++; end
        n_checks++; if (sd != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses exp 0", sd); end
        blk_valid = 1'b1;
        collect(100, 1'b0, 1'b1, -1, 1'b0);
        n_checks++; if (q_data.size() != 64) begin n_fail++; $display("FAIL rst_mid_count: got %0d exp 64", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 64; i++) begin
            n_checks++;
            if (q_data[i] !== ref_w[i] || q_idx[i] != i) begin
                n_fail++; $display("FAIL rst_mid_word%0d: got %h/%0d exp %h/%0d", i, q_data[i], q_idx[i], ref_w[i], i);
            end
        end
        idle_gap();
    endtask

    task automatic test_input_change();
        pad_mem = abc_block();
        compute_ref(pad_mem);
        blk_valid = 1'b1;
        collect(100, 1'b0, 1'b1, -1, 1'b1);
        n_checks++; if (acks != 1) begin n_fail++; $display("FAIL chg_ack_count: got %0d exp 1", acks); end
        n_checks++; if (q_data.size() != 64) begin n_fail++; $display("FAIL chg_count: got %0d exp 64", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 64; i++) begin
            n_checks++;
            if (q_data[i] !== ref_w[i]) begin
                n_fail++; $display("FAIL chg_word%0d: got %h exp %h", i, q_data[i], ref_w[i]);
            end
        end
        idle_gap();
    endtask

    task automatic test_random_blocks();
        for (int n = 0; n < 3; n++) begin
            pad_mem = rand_block();
            compute_ref(pad_mem);
            blk_valid = 1'b1;
            collect(600, 1'b1, 1'b1, -1, 1'b0);
            n_checks++; if (q_data.size() != 64) begin n_fail++; $display("FAIL rnd%0d_count: got %0d exp 64", n, q_data.size()); end
            for (int i = 0; i < q_data.size() && i < 64; i++) begin
                n_checks++;
                if (q_data[i] !== ref_w[i] || q_idx[i] != i) begin
                    n_fail++; $display("FAIL rnd%0d_word%0d: got %h/%0d exp %h/%0d", n, i, q_data[i], q_idx[i], ref_w[i], i);
                end
            end
            n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL rnd%0d_stall_stable: got %0d exp 0", n, stall_err); end
            idle_gap();
        end
    endtask

    task automatic test_rounds17();
        logic [31:0] got [$];
        int          last_idx, dcyc, acnt;
        pad_mem = abc_block();
        compute_ref(pad_mem);
        last_idx = -1; dcyc = -1; acnt = 0;
        w_ready17 = 1'b1;
        blk_valid17 = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (blk_ack17) acnt++;
            if (w_valid17 && w_ready17) begin got.push_back(w_data17); last_idx = int'(w_idx17); end
            if (sched_done17) begin dcyc = c; break; end
        end
        blk_valid17 = 1'b0;
        n_checks++; if (got.size() != 17) begin n_fail++; $display("FAIL r17_count: got %0d exp 17", got.size()); end
        n_checks++; if (last_idx != 16) begin n_fail++; $display("FAIL r17_last_idx: got %0d exp 16", last_idx); end
        if (got.size() == 17) begin
            n_checks++; if (got[16] !== 32'h61626380) begin n_fail++; $display("FAIL r17_W16: got %h exp 61626380", got[16]); end
            for (int i = 0; i < 17; i++) begin
                n_checks++;
                if (got[i] !== ref_w[i]) begin n_fail++; $display("FAIL r17_word%0d: got %h exp %h", i, got[i], ref_w[i]); end
            end
        end
        n_checks++; if (dcyc != 18) begin n_fail++; $display("FAIL r17_done_cycle: got %0d exp 18", dcyc); end
        n_checks++; if (acnt != 1) begin n_fail++; $display("FAIL r17_ack_count: got %0d exp 1", acnt); end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_backpressure();
        test_level_hold();
        test_reset_mid();
        test_input_change();
        test_random_blocks();
        test_rounds17();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
